pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 124 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: per-stage enables, flushes and valid tracking for an
// in-order pipeline, with run / single-step / drain / halt control and counters.
module pipeline_sequencer #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_clear,
    input  logic                  i_mode,
    input  logic                  i_step,
    input  logic                  i_halt_ext,
    input  logic                  i_load_use,
    input  logic                  i_flush_if,
    input  logic                  i_halt_instr,
    output logic [NUM_STAGES-1:0] o_stage_en,
    output logic [NUM_STAGES-1:0] o_stage_flush,
    output logic [NUM_STAGES-1:0] o_valid,
    output logic [2:0]            o_state,
    output logic                  o_drained,
    output logic [CNT_WIDTH-1:0]  o_cycle_cnt,
    output logic [CNT_WIDTH-1:0]  o_retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_STAGES-1:0]   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]    cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]    retired_q, retired_d;

    logic adv;
    logic halt_tr;
    logic run_like;
    logic step_like;
    logic issuing;

    // Advance qualification, enables, flushes and next-state logic.
    always_comb begin
        run_like      = (state_q == ST_RUN)  || (state_q == ST_DRAIN);
        step_like     = (state_q == ST_STEP) || (state_q == ST_DRAIN);
        issuing       = (state_q == ST_RUN)  || (state_q == ST_STEP);
        adv           = ~i_halt_ext & ((run_like & ~i_mode) | (step_like & i_mode & i_step));
        halt_tr       = issuing & adv & i_halt_instr & ~i_load_use;

        o_stage_en    = {NUM_STAGES{adv}};
        o_stage_en[0] = adv & ~i_load_use;
        o_stage_en[1] = adv & ~i_load_use;

        o_stage_flush    = '0;
        o_stage_flush[1] = adv & i_flush_if & ~i_load_use;
        o_stage_flush[2] = adv & i_load_use;

        valid_d   = valid_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;
        state_d   = state_q;

        if (adv) begin
            // Fetch stops on the halt edge so only HALT and older instructions drain.
            valid_d[0] = issuing & ~halt_tr;
            if (!i_load_use) begin
                valid_d[1] = (i_flush_if | halt_tr) ? 1'b0 : valid_q[0];
            end
            valid_d[2] = i_load_use ? 1'b0 : valid_q[1];
            for (int unsigned k = 3; k < NUM_STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
            end
            cycle_d   = cycle_q + CNT_WIDTH'(1);
            retired_d = retired_q + CNT_WIDTH'(valid_q[NUM_STAGES-1]);
        end

        if (!i_halt_ext) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) state_d = i_mode ? ST_STEP : ST_RUN;
                end
                ST_RUN, ST_STEP: begin
                    if (halt_tr) state_d = ST_DRAIN;
                    else         state_d = i_mode ? ST_STEP : ST_RUN;
                end
                ST_DRAIN: begin
                    if (valid_q == '0) state_d = ST_HALTED;
                end
                ST_HALTED: begin
                    if (i_clear) begin
                        state_d   = ST_IDLE;
                        cycle_d   = '0;
                        retired_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            valid_q   <= '0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_state     = state_q;
    assign o_drained   = ~|valid_q;
    assign o_cycle_cnt = cycle_q;
    assign o_retired   = retired_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: a cycle-by-cycle vector table with a
// post-edge scoreboard, plus step, drain, external-halt and async-reset sequences.
module tb_pipeline_sequencer;

    localparam int unsigned NS = 5;
    localparam int unsigned CW = 32;

    localparam logic [7:0] S = 8'h80;  // start
    localparam logic [7:0] C = 8'h40;  // clear
    localparam logic [7:0] M = 8'h20;  // step mode
    localparam logic [7:0] P = 8'h10;  // step pulse
    localparam logic [7:0] X = 8'h08;  // external halt
    localparam logic [7:0] L = 8'h04;  // load-use
    localparam logic [7:0] F = 8'h02;  // flush IF
    localparam logic [7:0] H = 8'h01;  // halt instruction

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0, i_clear = 1'b0, i_mode = 1'b0, i_step = 1'b0;
    logic          i_halt_ext = 1'b0, i_load_use = 1'b0, i_flush_if = 1'b0, i_halt_instr = 1'b0;
    logic [NS-1:0] o_stage_en, o_stage_flush, o_valid;
    logic [2:0]    o_state;
    logic          o_drained;
    logic [CW-1:0] o_cycle_cnt, o_retired;

    pipeline_sequencer #(.NUM_STAGES(NS), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_clear(i_clear),
        .i_mode(i_mode), .i_step(i_step), .i_halt_ext(i_halt_ext),
        .i_load_use(i_load_use), .i_flush_if(i_flush_if), .i_halt_instr(i_halt_instr),
        .o_stage_en(o_stage_en), .o_stage_flush(o_stage_flush), .o_valid(o_valid),
        .o_state(o_state), .o_drained(o_drained), .o_cycle_cnt(o_cycle_cnt),
        .o_retired(o_retired)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  in;
        logic [4:0]  en;
        logic [4:0]  fo;
        logic [2:0]  st;
        logic [4:0]  val;
        logic [31:0] cyc;
        logic [31:0] ret;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic [4:0]  val;
        logic [31:0] cyc;
        logic [31:0] ret;
    } post_t;

    vec_t  tbl[29];
    post_t sb[$];
    int    total = 0;
    int    bad   = 0;

    function automatic vec_t mk(input logic [7:0] in, input logic [4:0] en, input logic [4:0] fo,
                                input logic [2:0] st, input logic [4:0] val,
                                input logic [31:0] cyc, input logic [31:0] ret);
        vec_t v;
        v.in = in; v.en = en; v.fo = fo; v.st = st; v.val = val; v.cyc = cyc; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] in);
        {i_start, i_clear, i_mode, i_step, i_halt_ext, i_load_use, i_flush_if, i_halt_instr} = in;
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Drive one cycle of inputs at negedge, check combinational outputs, then the post-edge state.
    task automatic apply(input vec_t v, input int idx);
        post_t p;
        @(negedge i_clk);
        set_in(v.in);
        #1;
        chk($sformatf("v%0d_en", idx), 32'(o_stage_en), 32'(v.en));
        chk($sformatf("v%0d_flush", idx), 32'(o_stage_flush), 32'(v.fo));
        p.st = v.st; p.val = v.val; p.cyc = v.cyc; p.ret = v.ret;
        sb.push_back(p);
        tick;
        p = sb.pop_front();
        chk($sformatf("v%0d_state", idx), 32'(o_state), 32'(p.st));
        chk($sformatf("v%0d_valid", idx), 32'(o_valid), 32'(p.val));
        chk($sformatf("v%0d_cycles", idx), o_cycle_cnt, p.cyc);
        chk($sformatf("v%0d_retired", idx), o_retired, p.ret);
        chk($sformatf("v%0d_drained", idx), 32'(o_drained), 32'(p.val == 5'd0));
    endtask

    task automatic cyc_in(input logic [7:0] in);
        @(negedge i_clk);
        set_in(in);
        tick;
    endtask

    task automatic do_reset;
        @(negedge i_clk);
        set_in(8'h00);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        int n;
        // Continuous run, load-use bubble, flush, mode switch, step-mode drain, halt, clear.
        tbl[0] = mk(S, 5'h00, 5'h00, 3'd1, 5'h00, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            tbl[k] = mk(8'h00, 5'h1f, 5'h00, 3'd1, (k >= 5) ? 5'h1f : 5'((1 << k) - 1),
                        32'(k), (k > 5) ? 32'(k - 5) : 32'd0);
        end
        tbl[11] = mk(L,       5'b11100, 5'b00100, 3'd1, 5'b11011, 11, 6);
        tbl[12] = mk(8'h00,   5'b11111, 5'b00000, 3'd1, 5'b10111, 12, 7);
        tbl[13] = mk(8'h00,   5'b11111, 5'b00000, 3'd1, 5'b01111, 13, 8);
        tbl[14] = mk(8'h00,   5'b11111, 5'b00000, 3'd1, 5'b11111, 14, 8);
        tbl[15] = mk(F | L,   5'b11100, 5'b00100, 3'd1, 5'b11011, 15, 9);
        tbl[16] = mk(F,       5'b11111, 5'b00010, 3'd1, 5'b10101, 16, 10);
        tbl[17] = mk(M,       5'b00000, 5'b00000, 3'd2, 5'b10101, 16, 10);
        tbl[18] = mk(M,       5'b00000, 5'b00000, 3'd2, 5'b10101, 16, 10);
        tbl[19] = mk(M|P,     5'b11111, 5'b00000, 3'd2, 5'b01011, 17, 11);
        tbl[20] = mk(M|P|X,   5'b00000, 5'b00000, 3'd2, 5'b01011, 17, 11);
        tbl[21] = mk(M|P|H,   5'b11111, 5'b00000, 3'd3, 5'b10100, 18, 11);
        tbl[22] = mk(M,       5'b00000, 5'b00000, 3'd3, 5'b10100, 18, 11);
        tbl[23] = mk(M|P,     5'b11111, 5'b00000, 3'd3, 5'b01000, 19, 12);
        tbl[24] = mk(M|P,     5'b11111, 5'b00000, 3'd3, 5'b10000, 20, 12);
        tbl[25] = mk(M|P,     5'b11111, 5'b00000, 3'd3, 5'b00000, 21, 13);
        tbl[26] = mk(M,       5'b00000, 5'b00000, 3'd4, 5'b00000, 21, 13);
        tbl[27] = mk(S|M,     5'b00000, 5'b00000, 3'd4, 5'b00000, 21, 13);
        tbl[28] = mk(C|M,     5'b00000, 5'b00000, 3'd0, 5'b00000, 0, 0);

        do_reset;
        #1;
        chk("reset_state", 32'(o_state), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_drained", 32'(o_drained), 32'd1);
        chk("reset_en", 32'(o_stage_en), 32'd0);
        chk("reset_cycles", o_cycle_cnt, 32'd0);

        for (int i = 0; i < 29; i++) apply(tbl[i], i);

        // Step mode: three pulses spaced four cycles apart give exactly three advances.
        do_reset;
        cyc_in(S | M);
        for (int p = 0; p < 3; p++) begin
            @(negedge i_clk);
            set_in(M | P);
            #1;
            chk($sformatf("step%0d_en", p), 32'(o_stage_en), 32'h1f);
            tick;
            repeat (3) cyc_in(M);
        end
        chk("step_cycles", o_cycle_cnt, 32'd3);
        chk("step_valid", 32'(o_valid), 32'b00111);
        chk("step_state", 32'(o_state), 32'd2);

        // Halt from steady run: four cycles in DRAIN, then clear.
        do_reset;
        cyc_in(S);
        repeat (6) cyc_in(8'h00);
        cyc_in(H);
        chk("halt_state", 32'(o_state), 32'd3);
        chk("halt_valid", 32'(o_valid), 32'b11100);
        set_in(8'h00);
        n = 0;
        while (o_state == 3'd3 && n < 20) begin
            tick;
            n++;
        end
        chk("drain_cycles", 32'(n), 32'd4);
        chk("drain_state", 32'(o_state), 32'd4);
        chk("drain_cycle_cnt", o_cycle_cnt, 32'd11);
        chk("drain_retired", o_retired, 32'd5);
        cyc_in(C);
        chk("clear_state", 32'(o_state), 32'd0);
        chk("clear_cycles", o_cycle_cnt, 32'd0);
        chk("clear_retired", o_retired, 32'd0);

        // External freeze for five cycles, then asynchronous reset mid-drain.
        do_reset;
        cyc_in(S);
        repeat (3) cyc_in(8'h00);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            set_in(X | L | F);
            #1;
            chk($sformatf("hext%0d_en", c), 32'(o_stage_en), 32'd0);
            chk($sformatf("hext%0d_flush", c), 32'(o_stage_flush), 32'd0);
            tick;
            chk($sformatf("hext%0d_cycles", c), o_cycle_cnt, 32'd3);
            chk($sformatf("hext%0d_valid", c), 32'(o_valid), 32'b00111);
        end
        repeat (2) cyc_in(8'h00);
        cyc_in(H);
        chk("hext_drain_state", 32'(o_state), 32'd3);
        @(negedge i_clk);
        set_in(8'h00);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(o_state), 32'd0);
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_en", 32'(o_stage_en), 32'd0);
        chk("arst_cycles", o_cycle_cnt, 32'd0);
        chk("arst_drained", 32'(o_drained), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) cyc_in(8'h00);
        chk("post_rst_state", 32'(o_state), 32'd0);
        chk("post_rst_cycles", o_cycle_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
